// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, fetch FSM states and instruction-queue entry type.
package fetch_stage_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef enum logic {RUN, HALT} fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fq_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus bundle.
//   control : jb, jb_target (redirect from execute), stall (decode back-pressure)
//   imem    : imem_req/imem_addr/imem_gnt request side, imem_rvalid/imem_rdata response side
//   IF/ID   : F_out_inst, F_out_pc, F_out_valid, plus fetch_misaligned status
//   master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic            jb;
    logic [XLEN-1:0] jb_target;
    logic            stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] F_out_inst;
    logic [XLEN-1:0] F_out_pc;
    logic            F_out_valid;
    logic            fetch_misaligned;
    modport master (
        input  jb, jb_target, stall, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, F_out_inst, F_out_pc, F_out_valid, fetch_misaligned
    );
    modport slave (
        output jb, jb_target, stall, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, F_out_inst, F_out_pc, F_out_valid, fetch_misaligned
    );
endinterface

// File: rtl/fetch_stage_queue.sv
// fetch_queue: synchronous FIFO of {inst, pc} entries; flush overrides push and pop.
//   clk, rst           : clock, asynchronous active-high reset
//   push_i, wdata_i    : enqueue an entry
//   pop_i              : dequeue the head entry
//   flush_i            : empty the queue
//   head_o, count_o    : head entry and occupancy
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fq_entry_t     wdata_i,
    output fq_entry_t     head_o,
    output logic [CW-1:0] count_o
);
    fq_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch; owns the PC, issues credit-limited in-order imem
// requests, queues responses with their PCs for IF/ID, drops in-flight data on redirect.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master (redirect, stall, imem request/response, IF/ID outputs)
// Optional feature: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target sets the sticky
// fetch_misaligned flag and halts fetching until reset; otherwise target[1:0] is forced to 0.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int QDEPTH = 2
) (
    input logic clk,
    input logic rst,
    fetch_stage_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, target;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, qcount;
    logic [AW-1:0] twr_q, trd_q;
    logic [XLEN-1:0] tpc_q [QDEPTH];
    logic rsp, grant, push, pop, valid;
    fq_entry_t wdata, head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign target = bus.jb_target;
`else
    assign target = bus.jb_target & ~XLEN'(3);
`endif

    // A request is only issued when every in-flight response is guaranteed a queue slot.
    assign bus.imem_req = (state_q == RUN) && !bus.jb &&
                          (({1'b0, outstanding_q} + {1'b0, qcount}) < (CW + 1)'(QDEPTH));
    assign bus.imem_addr = pc_q;

    always_comb begin
        // Responses with nothing outstanding predate a reset and are ignored.
        rsp           = bus.imem_rvalid && (outstanding_q != '0);
        valid         = qcount != '0;
        grant         = bus.imem_req && bus.imem_gnt;
        push          = rsp && (drop_cnt_q == '0) && !bus.jb;
        pop           = valid && !bus.stall && !bus.jb;
        wdata         = '{inst: bus.imem_rdata, pc: tpc_q[trd_q]};
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
        // On redirect, everything still in flight after this edge must be discarded.
        drop_cnt_d    = bus.jb ? outstanding_q - CW'(rsp)
                               : drop_cnt_q - CW'(rsp && (drop_cnt_q != '0));
        pc_d          = bus.jb ? target : (grant ? pc_q + PC_STEP : pc_q);
        state_d       = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d         = mis_q || (bus.jb && (target[1:0] != 2'b00));
        state_d       = mis_d ? HALT : state_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            twr_q         <= '0;
            trd_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            twr_q         <= twr_q + AW'(grant);
            trd_q         <= trd_q + AW'(rsp);
        end
    end

    // PCs of granted requests, consumed in order as responses return.
    always_ff @(posedge clk) begin
        if (grant) tpc_q[twr_q] <= pc_q;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
    assign bus.fetch_misaligned = mis_q;
`else
    assign bus.fetch_misaligned = 1'b0;
`endif

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.jb),
        .wdata_i (wdata),
        .head_o  (head),
        .count_o (qcount)
    );

    assign bus.F_out_valid = valid;
    assign bus.F_out_inst  = valid ? head.inst : NOP_INST;
    assign bus.F_out_pc    = valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a configurable-latency memory model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] pc; int epoch; } fl_t;
    rsp_t      rsp_q[$];
    fl_t       infl[$];
    fq_entry_t exp_q[$];

    int n_vec = 0, n_err = 0;
    int cyc, lat, last_due, epoch;
    logic [31:0] model_pc;
    bit halted;
    logic obs_req, obs_valid, obs_mis;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0033;
    endfunction

    // One clock cycle: drive memory response, check outputs against the model, update model.
    task automatic step();
        fl_t r;
        bit rv, keep, pop, g, exp_req;
        rv = 0;
        keep = 0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            rv = 1;
            bus.imem_rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_rvalid = rv;
        #1;
        obs_req = bus.imem_req; obs_addr = bus.imem_addr; obs_valid = bus.F_out_valid;
        obs_pc = bus.F_out_pc; obs_inst = bus.F_out_inst; obs_mis = bus.fetch_misaligned;
        n_vec++;
        if (bus.F_out_valid !== (exp_q.size() > 0)) begin
            n_err++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, bus.F_out_valid, exp_q.size() > 0);
        end
        n_vec++;
        if (exp_q.size() > 0) begin
            if ({bus.F_out_inst, bus.F_out_pc} !== exp_q[0]) begin
                n_err++;
                $display("FAIL head cyc=%0d got inst=%h pc=%h exp inst=%h pc=%h", cyc,
                         bus.F_out_inst, bus.F_out_pc, exp_q[0].inst, exp_q[0].pc);
            end
        end else if ({bus.F_out_inst, bus.F_out_pc} !== {NOP_INST, 32'h0}) begin
            n_err++;
            $display("FAIL idle_out cyc=%0d got inst=%h pc=%h exp inst=%h pc=0", cyc,
                     bus.F_out_inst, bus.F_out_pc, NOP_INST);
        end
        exp_req = !halted && !bus.jb && (infl.size() + exp_q.size() < QD);
        n_vec++;
        if (bus.imem_req !== exp_req) begin
            n_err++;
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, exp_req);
        end
        g = bus.imem_req && bus.imem_gnt;
        if (rv && infl.size() > 0) begin
            r = infl.pop_front();
            keep = (r.epoch == epoch) && !bus.jb;
        end
        if (g) begin
            n_vec++;
            if (bus.imem_addr !== model_pc) begin
                n_err++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, model_pc);
            end
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            rsp_q.push_back('{due: last_due, data: inst_of(bus.imem_addr)});
            infl.push_back('{pc: model_pc, epoch: epoch});
            model_pc += 32'd4;
        end
        pop = exp_q.size() > 0 && !bus.stall && !bus.jb;
        if (bus.jb) begin
            exp_q.delete();
            epoch++;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.jb_target[1:0] != 2'b00) halted = 1;
            model_pc = bus.jb_target;
`else
            model_pc = {bus.jb_target[31:2], 2'b00};
`endif
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (keep) exp_q.push_back('{inst: inst_of(r.pc), pc: r.pc});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] t, input bit st);
        bus.jb = 1; bus.jb_target = t; bus.stall = st;
        step();
        n_vec++;
        if (obs_req !== 1'b0) begin
            n_err++;
            $display("FAIL req_in_jb got=%b exp=0", obs_req);
        end
        bus.jb = 0; bus.stall = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.jb = 0; bus.jb_target = 0; bus.stall = 0; bus.imem_gnt = 0;
        bus.imem_rvalid = 0; bus.imem_rdata = 0;
        cyc = 0; lat = 1; last_due = 0; epoch = 0; model_pc = 32'h0; halted = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.F_out_valid, bus.F_out_inst, bus.F_out_pc, bus.fetch_misaligned, bus.imem_addr}
            !== {1'b0, NOP_INST, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset got v=%b inst=%h pc=%h mis=%b addr=%h exp v=0 inst=13 pc=0 mis=0 addr=0",
                     bus.F_out_valid, bus.F_out_inst, bus.F_out_pc, bus.fetch_misaligned, bus.imem_addr);
        end
        rst = 0;
        bus.imem_gnt = 1;
    endtask

    task automatic test_stream();
        int seen;
        lat = 1;
        repeat (12) step();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen += int'(obs_valid);
        end
        n_vec++;
        if (seen != 8) begin
            n_err++;
            $display("FAIL throughput got=%0d exp=8", seen);
        end
    endtask

    task automatic test_stall();
        int drained;
        bus.stall = 1;
        repeat (8) step();
        n_vec++;
        if ({obs_req, obs_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL stall_full got req=%b valid=%b exp req=0 valid=1", obs_req, obs_valid);
        end
        bus.imem_gnt = 0;
        bus.stall = 0;
        drained = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!obs_valid) break;
            drained++;
        end
        n_vec++;
        if (drained != QD) begin
            n_err++;
            $display("FAIL stall_held got=%0d exp=%0d", drained, QD);
        end
        bus.imem_gnt = 1;
        repeat (4) step();
    endtask

    task automatic test_redirect();
        bit found;
        lat = 2;
        repeat (10) step();
        redirect(32'h100, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = obs_valid;
        end
        n_vec++;
        if (!found || obs_pc !== 32'h100 || obs_inst !== inst_of(32'h100)) begin
            n_err++;
            $display("FAIL redirect_first got found=%b pc=%h inst=%h exp pc=100 inst=%h",
                     found, obs_pc, obs_inst, inst_of(32'h100));
        end
        repeat (6) step();
    endtask

    task automatic test_jb_stall();
        int k;
        lat = 1;
        repeat (6) step();
        bus.stall = 1;
        repeat (2) step();
        redirect(32'h200, 1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) begin
                n_vec++;
                if ({obs_valid, obs_req, obs_addr} !== {1'b0, 1'b1, 32'h200}) begin
                    n_err++;
                    $display("FAIL jb_stall_next got valid=%b req=%b addr=%h exp valid=0 req=1 addr=200",
                             obs_valid, obs_req, obs_addr);
                end
            end
            if (obs_valid) begin k = i; break; end
        end
        n_vec++;
        if (k != 3 || obs_pc !== 32'h200) begin
            n_err++;
            $display("FAIL jb_latency got cycles=%0d pc=%h exp cycles=3 pc=200", k, obs_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFC, 0);
        step();
        n_vec++;
        if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL wrap_a got req=%b addr=%h exp req=1 addr=fffffffc", obs_req, obs_addr);
        end
        step();
        n_vec++;
        if ({obs_req, obs_addr} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL wrap_b got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr);
        end
        repeat (6) step();
    endtask

    task automatic test_misalign();
        redirect(32'h102, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({obs_req, obs_mis} !== 2'b01) begin
                n_err++;
                $display("FAIL misalign_halt got req=%b mis=%b exp req=0 mis=1", obs_req, obs_mis);
            end
        end
`else
        step();
        n_vec++;
        if ({obs_req, obs_addr, obs_mis} !== {1'b1, 32'h100, 1'b0}) begin
            n_err++;
            $display("FAIL misalign_off got req=%b addr=%h mis=%b exp req=1 addr=100 mis=0",
                     obs_req, obs_addr, obs_mis);
        end
        repeat (6) step();
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_jb_stall();
        test_wrap();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage of the RV32I pipeline.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned instructions and presents them, with their PC, to the IF/ID register.
- Honours decode-stage stalls and flushes all fetch state on a taken jump/branch (`jb`) redirect from execute.

## Interface
Parameters:
- `RESET_PC` — default 32'h0000_0000 — first fetch address after reset.
- `QDEPTH` — default 2 — instruction-queue entries; power of two, ≥2.

Ports:
- `clk` — in — 1 — single clock; all state updates on posedge.
- `rst` — in — 1 — asynchronous, active-high reset.
- `jb` — in — 1 — redirect: taken jump/branch from execute.
- `jb_target` — in — 32 — redirect address, valid when `jb`=1.
- `stall` — in — 1 — decode cannot accept this cycle.
- `imem_req` — out — 1 — fetch request valid.
- `imem_addr` — out — 32 — fetch address (= `pc`).
- `imem_gnt` — in — 1 — request accepted this cycle.
- `imem_rvalid` — in — 1 — response valid; responses in request order, ≥1 cycle after grant.
- `imem_rdata` — in — 32 — returned instruction.
- `F_out_inst` — out — 32 — instruction to IF/ID; 32'h00000013 when not valid.
- `F_out_pc` — out — 32 — PC of `F_out_inst`; 0 when not valid.
- `F_out_valid` — out — 1 — queue head valid.
- `fetch_misaligned` — out — 1 — sticky misaligned-redirect flag (macro only; tied 0 otherwise).

## Operation
- State: `pc`, `outstanding` (0..QDEPTH), `drop_cnt` (0..QDEPTH), queue (count 0..QDEPTH, storing {inst, pc}), FSM {RUN, HALT}.
- Credit rule: `imem_req` = (state==RUN) && !`jb` && (`outstanding` + qcount < QDEPTH). This guarantees every response has a queue slot.
- Grant (`imem_req`&&`imem_gnt`): `pc` <= `pc`+4 (32-bit wrap, 32'hFFFF_FFFC → 0). The request's pc is tracked in a pc-FIFO alongside `outstanding`.
- `outstanding` changes by +1 on grant and −1 on any `imem_rvalid`, including dropped responses.
- Response handling:
  - If `drop_cnt`>0 or `jb`: discard; `drop_cnt` decrements if nonzero.
  - Otherwise push {`imem_rdata`, tracked pc}.
- Pop when `F_out_valid` && !`stall` && !`jb`.
- Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (`jb`=1), with priority over `stall`:
  - Queue is cleared and `pc` <= `jb_target`.
  - `drop_cnt` <= `outstanding` − `imem_rvalid`, plus the current `drop_cnt` contribution already counted in `outstanding`. Net effect: every response still in flight after this edge is dropped.
  - No request is issued in the `jb` cycle.
- Outputs are combinational from the queue head: `F_out_*` = head when qcount>0, else NOP/0.

## Timing
- Reset values:
  - `pc`=RESET_PC, `outstanding`=0, `drop_cnt`=0, queue empty, state=RUN.
  - `imem_req` may assert in the first cycle after `rst` falls; `F_out_valid`=0, `F_out_inst`=32'h13, `F_out_pc`=0, `fetch_misaligned`=0.
- Response→output latency: an `imem_rvalid` at cycle t is visible on `F_out_*` at t+1. There is no bypass.
- Redirect: the `jb` at cycle t produces a request to `jb_target` at t+1 when credit allows. The first valid post-redirect output is no earlier than t+3 for 1-cycle memory.
- Reset mid-operation clears all state immediately. Responses arriving afterwards belong to the memory side and are not tracked.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A `jb` with `jb_target[1:0]`≠0 sets `fetch_misaligned`=1 and moves the FSM to HALT.
  - The queue is flushed and in-flight responses are dropped.
  - `imem_req` stays 0 until reset.
- Macro undefined: `jb_target[1:0]` is forced to 0, HALT is unreachable, and `fetch_misaligned` is tied 0.

## Structure
- Shared package holds:
  - `NOP_INST`=32'h00000013
  - `XLEN`=32
  - `PC_STEP`=4
  - the fetch state enum {RUN, HALT}
- Sub-module `fetch_queue`: synchronous FIFO of {inst, pc}, with push, pop, flush, count, head outputs, and flush overriding push and pop.

## Test plan
- Reset release, `imem_gnt`=1, 1-cycle memory returning addr-derived data → PCs 0,4,8… appear in order. Steady-state throughput is one instruction per cycle with `stall`=0.
- `stall`=1 for 5 cycles with the queue full → exactly QDEPTH entries held, `imem_req`=0, no loss. After release, entries drain in order.
- `jb`=1 to 32'h100 with 2 requests outstanding → both responses discarded, next output is pc 32'h100 with its data, and no stale PC appears.
- `jb` and `stall` asserted together → queue flushed, `F_out_valid`=0 next cycle, fetch resumes at target.
- PC wrap: `jb_target`=32'hFFFF_FFFC → next request address is 0.
- With the macro defined, `jb_target`=32'h102 → `fetch_misaligned`=1, state HALT, `imem_req`=0 forever. With the macro undefined, fetch proceeds from 32'h100.
